// File: rtl/simple_system_sensor_conditioner.sv
// simple_system_sensor_conditioner: per-channel synchronizer and debouncer with sticky change flags and a shared change strobe.
module simple_system_sensor_conditioner #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             clear_changes,
  output logic [WIDTH-1:0] sensor_out,
  output logic [WIDTH-1:0] changed,
  output logic             change_strobe
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, sync2, accept;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sensor_out <= '0;
      changed <= '0;
      change_strobe <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      sensor_out <= sensor_out ^ accept;
      changed <= (clear_changes ? '0 : changed) | accept;
      change_strobe <= |accept;
    end
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [CW-1:0] cnt;
    logic mismatch;
    always_comb begin
      mismatch = sync2[g] != sensor_out[g];
      accept[g] = mismatch && cnt == LAST;
    end
    // a match or an acceptance restarts the count, so it never wraps
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else cnt <= (!mismatch || accept[g]) ? '0 : cnt + CW'(1);
  end
endmodule

// File: doc/simple_system_sensor_conditioner.md
SIMPLE_SYSTEM_SENSOR_CONDITIONER -- requirements
Module: simple_system_sensor_conditioner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of sensor channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz), giving the consecutive stable cycles required to accept a level change; legal range >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port raw_in, input, WIDTH bits: asynchronous sensor lines from the FPGA pins.
REQ-006 The block SHALL have port clear_changes, input, 1 bit: synchronous clear of the sticky change flags.
REQ-007 The block SHALL have port sensor_out, output, WIDTH bits: the debounced levels, driving the sensor PIO in_port.
REQ-008 The block SHALL have port changed, output, WIDTH bits: sticky per-channel flags marking accepted transitions.
REQ-009 The block SHALL have port change_strobe, output, 1 bit: a one-cycle pulse on any accepted transition.

Function
REQ-010 Each raw_in bit SHALL pass through a two-flop synchronizer; only the second-stage value (sync[i]) feeds the debounce logic.
REQ-011 Each channel SHALL have an independent counter sized to hold DEBOUNCE_CYCLES-1 (width clog2(DEBOUNCE_CYCLES), minimum 1).
REQ-012 When sync[i] == sensor_out[i], counter[i] SHALL load 0 on the next edge.
REQ-013 When sync[i] != sensor_out[i] and counter[i] < DEBOUNCE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-014 When sync[i] != sensor_out[i] and counter[i] == DEBOUNCE_CYCLES-1, on the same edge: sensor_out[i] <= sync[i]; counter[i] <= 0; changed[i] <= 1; and change_strobe <= 1.
REQ-015 Latency: a raw_in level held stable SHALL appear on sensor_out exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-016 A mismatch lasting fewer than DEBOUNCE_CYCLES cycles at sync[i] SHALL leave sensor_out[i], changed[i], and change_strobe unchanged, and SHALL return counter[i] to 0.
REQ-017 The counter SHALL never wrap; the value DEBOUNCE_CYCLES-1 is terminal and always results in acceptance.
REQ-018 change_strobe SHALL be high for exactly one cycle per accepting edge, including when several channels accept on the same edge (one pulse, not one per channel); it SHALL be 0 otherwise.
REQ-019 clear_changes high SHALL zero every changed bit on the next edge, except any bit whose channel accepts a transition on that same edge, which SHALL read 1 (set wins).
REQ-020 Channels SHALL be fully independent; activity on one SHALL NOT affect another's counter or output.
REQ-021 With DEBOUNCE_CYCLES == 1, any synchronized mismatch SHALL be accepted on the first edge it is seen.

Reset
REQ-022 While reset_n is low, synchronizer flops, counters, sensor_out, changed, and change_strobe SHALL all be 0, asynchronously.
REQ-023 Reset asserted mid-count SHALL discard any partial count; after release, counting restarts from 0.
REQ-024 If raw_in is 1 when reset is released, that channel SHALL be accepted normally after DEBOUNCE_CYCLES+2 edges, setting its changed bit and pulsing change_strobe.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4)
REQ-025 Drive raw_in 0000 -> 0001 held -> sensor_out = 0001 exactly 6 edges later; changed = 0001; one change_strobe pulse.
REQ-026 Pulse raw_in[2] high for 3 cycles, then low -> sensor_out, changed, and change_strobe never change.
REQ-027 Drive raw_in 0000 -> 1010 on the same cycle -> both bits update on the same edge; changed = 1010; exactly one strobe cycle.
REQ-028 Assert clear_changes on the edge where channel 0 accepts, with changed previously = 1000 -> changed = 0001.
REQ-029 Assert reset_n low when counter = 2, then release with raw_in held at 0001 -> all outputs are 0 during reset; sensor_out = 0001 six edges after release.
REQ-030 Toggle raw_in[3] every 4 cycles, continuously -> after synchronization each level is held 4 cycles and is accepted on each toggle; verify the strobe count equals the toggle count.
